// File: rtl/up_core_param.sv
// Parametrised two-word accumulator CPU core: FETCH -> EXEC -> (MEMWB) -> FETCH.
// Optional build macro UP_ADC_EN turns ADDI/ADDM into add-with-carry and CMPI/CMPM into subtract-with-borrow.
module up_core_param #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 12
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_run,
    input  logic [DATA_W-1:0] i_pushbuttons,
    output logic [ADDR_W-1:0] o_prog_addr,
    input  logic [DATA_W+3:0] i_prog_data,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic              o_ram_we,
    output logic              o_ram_re,
    output logic [DATA_W-1:0] o_ram_wdata,
    input  logic [DATA_W-1:0] i_ram_rdata,
    output logic [DATA_W-1:0] o_out_port,
    output logic              o_phase,
    output logic              o_c_flag,
    output logic              o_z_flag,
    output logic [3:0]        o_instr,
    output logic [DATA_W-1:0] o_oprnd,
    output logic [DATA_W-1:0] o_accu,
    output logic [ADDR_W-1:0] o_pc
);

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_MEMWB = 2'd2;

    localparam logic [3:0] OP_JC    = 4'b0000;
    localparam logic [3:0] OP_JNC   = 4'b0001;
    localparam logic [3:0] OP_CMPI  = 4'b0010;
    localparam logic [3:0] OP_CMPM  = 4'b0011;
    localparam logic [3:0] OP_LIT   = 4'b0100;
    localparam logic [3:0] OP_IN    = 4'b0101;
    localparam logic [3:0] OP_LD    = 4'b0110;
    localparam logic [3:0] OP_ST    = 4'b0111;
    localparam logic [3:0] OP_JZ    = 4'b1000;
    localparam logic [3:0] OP_JNZ   = 4'b1001;
    localparam logic [3:0] OP_ADDI  = 4'b1010;
    localparam logic [3:0] OP_ADDM  = 4'b1011;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_OUT   = 4'b1101;
    localparam logic [3:0] OP_NANDI = 4'b1110;
    localparam logic [3:0] OP_NANDM = 4'b1111;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_accu;
    logic              r_c;
    logic              r_z;
    logic [3:0]        r_instr;
    logic [DATA_W-1:0] r_oprnd;
    logic [DATA_W-1:0] r_out;

    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W-1:0] w_pc_inc;
    logic              w_in_exec;
    logic              w_is_mem_rd;
    logic              w_jump;
    logic [DATA_W-1:0] w_b;
    logic              w_cin;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W:0]   w_diff;
    logic [DATA_W-1:0] w_res;
    logic              w_c_new;
    logic              w_z_new;
    logic              w_wr_acc;
    logic              w_wr_flags;

    // The second word is still on i_prog_data during EXEC because pc already points at it.
    assign w_addr      = ADDR_W'({r_oprnd, i_prog_data});
    assign w_pc_inc    = r_pc + ADDR_W'(1);
    assign w_in_exec   = (r_state == ST_EXEC);
    assign w_is_mem_rd = (r_instr == OP_CMPM) || (r_instr == OP_LD) ||
                         (r_instr == OP_ADDM) || (r_instr == OP_NANDM);

    assign o_ram_we    = w_in_exec && (r_instr == OP_ST);
    assign o_ram_re    = w_in_exec && w_is_mem_rd;
    assign o_ram_addr  = w_addr;
    assign o_ram_wdata = r_accu;
    assign o_prog_addr = r_pc;
    assign o_pc        = r_pc;
    assign o_accu      = r_accu;
    assign o_c_flag    = r_c;
    assign o_z_flag    = r_z;
    assign o_instr     = r_instr;
    assign o_oprnd     = r_oprnd;
    assign o_out_port  = r_out;
    assign o_phase     = (r_state != ST_FETCH);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_jump = 1'b0;
        case (r_instr)
            OP_JC:   w_jump = r_c;
            OP_JNC:  w_jump = !r_c;
            OP_JZ:   w_jump = r_z;
            OP_JNZ:  w_jump = !r_z;
            OP_JMP:  w_jump = 1'b1;
            default: w_jump = 1'b0;
        endcase
    end

    assign w_b = (r_state == ST_MEMWB) ? i_ram_rdata :
                 (r_instr == OP_IN)    ? i_pushbuttons : r_oprnd;

`ifdef UP_ADC_EN
    assign w_cin = r_c;
`else
    assign w_cin = 1'b0;
`endif

    assign w_sum  = {1'b0, r_accu} + {1'b0, w_b} + {{DATA_W{1'b0}}, w_cin};
    assign w_diff = {1'b0, r_accu} - {1'b0, w_b} - {{DATA_W{1'b0}}, w_cin};

    always_comb begin
        w_res      = w_b;
        w_c_new    = 1'b0;
        w_wr_acc   = 1'b0;
        w_wr_flags = 1'b0;
        case (r_instr)
            OP_CMPI, OP_CMPM: begin
                w_res      = w_diff[DATA_W-1:0];
                w_c_new    = w_diff[DATA_W];
                w_wr_flags = 1'b1;
            end
            OP_LIT, OP_IN, OP_LD: begin
                w_wr_acc   = 1'b1;
                w_wr_flags = 1'b1;
            end
            OP_ADDI, OP_ADDM: begin
                w_res      = w_sum[DATA_W-1:0];
                w_c_new    = w_sum[DATA_W];
                w_wr_acc   = 1'b1;
                w_wr_flags = 1'b1;
            end
            OP_NANDI, OP_NANDM: begin
                w_res      = ~(r_accu & w_b);
                w_wr_acc   = 1'b1;
                w_wr_flags = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_z_new = (w_res == '0);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= ST_FETCH;
            r_pc    <= '0;
            r_accu  <= '0;
            r_c     <= 1'b0;
            r_z     <= 1'b0;
            r_instr <= '0;
            r_oprnd <= '0;
            r_out   <= '0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (i_run) begin
                        r_instr <= i_prog_data[DATA_W+3:DATA_W];
                        r_oprnd <= i_prog_data[DATA_W-1:0];
                        r_pc    <= w_pc_inc;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_pc <= w_jump ? w_addr : w_pc_inc;
                    if (w_is_mem_rd) begin
                        r_state <= ST_MEMWB;
                    end else begin
                        r_state <= ST_FETCH;
                        if (w_wr_acc)
                            r_accu <= w_res;
                        if (w_wr_flags) begin
                            r_c <= w_c_new;
                            r_z <= w_z_new;
                        end
                        if (r_instr == OP_OUT)
                            r_out <= r_accu;
                    end
                end
                ST_MEMWB: begin
                    r_state <= ST_FETCH;
                    if (w_wr_acc)
                        r_accu <= w_res;
                    if (w_wr_flags) begin
                        r_c <= w_c_new;
                        r_z <= w_z_new;
                    end
                end
                default: r_state <= ST_FETCH;
            endcase
        end
    end

endmodule

// File: doc/up_core_param.md
# up_core_param

Parametrised accumulator microprocessor core and next generation of the team's 4-bit nibble CPU, with the same two-word instruction stream, ISA and flag model. Data width and address width are generic. Program memory and data RAM are external ports; RAM is synchronous with a one-cycle read wait state. A run/hold control freezes the core at an instruction boundary. The core sits between the program ROM, data RAM, pushbutton inputs and an output latch.

## Interface
- DATA_W, 4, accumulator/operand/RAM/port data width (≥2)
- ADDR_W, 12, PC and RAM address width; must be ≤ 2*DATA_W+4
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- run  in  1  high: execute; low: hold in FETCH at instruction boundary
- pushbuttons  in  DATA_W  IN-instruction source, sampled in EXEC
- prog_addr  out  ADDR_W  program address (= pc)
- prog_data  in  DATA_W+4  combinational program word for prog_addr
- ram_addr  out  ADDR_W  {oprnd, word2} truncated to ADDR_W
- ram_we / ram_re  out  1  write strobe / read request, one cycle each
- ram_wdata  out  DATA_W  = accu
- ram_rdata  in  DATA_W  valid the cycle after ram_re
- out_port  out  DATA_W  output latch
- phase  out  1  0 in FETCH, 1 in EXEC/MEMWB
- c_flag, z_flag  out  1  flags
- instr  out  4 ; oprnd  out  DATA_W  latched first word
- accu  out  DATA_W ; pc  out  ADDR_W

## Operation
- Word format: prog_data = {instr[3:0], oprnd[DATA_W-1:0]}; every instruction is two words; word2 = prog_data during EXEC; imm = oprnd; addr = {oprnd, word2}[ADDR_W-1:0].
- FSM FETCH -> EXEC -> (MEMWB) -> FETCH.
- FETCH: if run, latch instr/oprnd, pc+1, go EXEC; else hold, no state change.
- EXEC: execute; pc+1, or pc<=addr on taken jump; mem-read ops assert ram_re and go MEMWB, others go FETCH.
- MEMWB: ALU op on ram_rdata, writeback, go FETCH.
- Opcodes (A=accu, flags F written where listed):
  - 0000 JC: jump if C
  - 0001 JNC: jump if !C
  - 0010 CMPI: F only, A−imm
  - 0011 CMPM: F only, A−RAM
  - 0100 LIT: A<=imm, F
  - 0101 IN: A<=pushbuttons, F
  - 0110 LD: A<=RAM, F
  - 0111 ST: RAM<=A
  - 1000 JZ: jump if Z
  - 1001 JNZ: jump if !Z
  - 1010 ADDI: A<=A+imm, F
  - 1011 ADDM: A<=A+RAM, F
  - 1100 JMP: unconditional
  - 1101 OUT: out_port<=A
  - 1110 NANDI: A<=~(A&imm), F
  - 1111 NANDM: A<=~(A&RAM), F
- Arithmetic on DATA_W+1 bits: add C = carry out; sub C = borrow (A<operand); pass/NAND C=0; Z = (DATA_W-bit result == 0) for every flag-writing op.
- Jump conditions use flags as they stand at EXEC; jumps never modify flags.
- pc wraps 2^ADDR_W−1 -> 0; a jump target overrides the increment.

## Timing
- Reset low: state=FETCH, pc=0, accu=0, flags=0, instr=0, oprnd=0, out_port=0, ram_we=ram_re=0, phase=0. First fetch occurs at the first rising edge after release with run=1.
- Register/jump/ST/OUT ops: 2 cycles. CMPM/LD/ADDM/NANDM: 3 cycles.
- ram_we and ram_re are combinational from state/instr and high only during EXEC. ram_addr is stable in EXEC.
- run sampled only in FETCH; deasserting run mid-instruction completes the instruction first.
- Reset asserted mid-instruction aborts it. No RAM write is issued after reset falls.

## Configuration
- UP_ADC_EN defined: ADDI/ADDM compute A+operand+C (add-with-carry); CMPI/CMPM compute A−operand−C (subtract-with-borrow), enabling multi-word arithmetic.
- Not defined: plain add/sub; C input ignored.

## Test plan
- Reset, LIT 5, OUT (DATA_W=4) -> out_port=5 after 4 cycles, z_flag=0, pc=4.
- LIT 0xF, ADDI 1 -> accu=0, C=1, Z=1. With UP_ADC_EN, a following ADDI 0 -> accu=1, C=0.
- ST to addr 0x123 then LD 0x123 with accu changed -> ram_we pulse in EXEC; LD takes 3 cycles; accu restored.
- CMPI 3 with accu=2 then JC 0x0A8 -> pc=0x0A8; JNC on the same flags -> pc advances by 2.
- run=0 during EXEC -> instruction completes, FSM holds in FETCH with pc frozen; run=1 resumes.
- JMP 0xFFE then execute at 0xFFE -> pc wraps to 0; reset pulse mid-LD -> all outputs at reset values, no ram_we.
